// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between EX and the iterative multiply/divide unit.
//   start, funct3, s_32, rs1, rs2, flush : requester -> unit
//   busy, done, result                   : unit -> requester
interface mdu_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic              start;
    logic [2:0]        funct3;
    logic              s_32;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              flush;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;

    modport master (
        output start, funct3, s_32, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, s_32, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, W forms on RV64).
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per cycle,
// sign fix-up and result selection in FIN.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : mdu_iter_if.slave (start/funct3/s_32/rs1/rs2/flush in, busy/done/result out)
// Parameters: XLEN (32 or 64), UNROLL (1, 2, 4 or 8).
// Optional feature macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero
// skip CALC and finish one edge after start.
module mdu_iter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input logic       clock,
    input logic       reset,
    mdu_iter_if.slave bus
);
    localparam int unsigned X2    = 2 * XLEN;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned WSH   = (XLEN > 32) ? 32 : 0;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    // Zero- or sign-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        ext32 = sgn ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              w32_q, w32_d;
    logic              neg_q, neg_d;       // product / quotient sign
    logic              negr_q, negr_d;     // remainder sign
    logic [X2-1:0]     acc_q, acc_d;       // product, or {remainder, dividend/quotient}
    logic [X2-1:0]     mc_q, mc_d;         // multiplicand (shifts left) or divisor
    logic [XLEN-1:0]   mp_q, mp_d;         // multiplier (shifts right)
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  nlast_q, nlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Request decode and operand magnitudes
    logic              is_mulh, w32_i, a_sgn, b_sgn, a_neg, b_neg, b_zero, q_neg_i;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, div_lo;
    logic [CNT_W-1:0]  nlast_i;
`ifdef MDU_EARLY_OUT_EN
    logic              a_zero, dz, ovf, mz;
    logic [XLEN-1:0]   min_w, min_mag, ones_w;
`endif

    always_comb begin
        is_mulh = !bus.funct3[2] && (bus.funct3[1:0] != 2'b00);
        w32_i   = (XLEN == 64) && bus.s_32 && !is_mulh;
        a_sgn   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_sgn   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_ext   = w32_i ? ext32(bus.rs1[31:0], a_sgn) : bus.rs1;
        b_ext   = w32_i ? ext32(bus.rs2[31:0], b_sgn) : bus.rs2;
        a_neg   = a_sgn && a_ext[XLEN-1];
        b_neg   = b_sgn && b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        b_zero  = (b_ext == {XLEN{1'b0}});
        // A zero divisor yields an all-ones quotient, so its sign is never flipped.
        q_neg_i = bus.funct3[2] ? ((a_neg ^ b_neg) && !b_zero) : (a_neg ^ b_neg);
        // W-form dividends sit in the upper half so the top bit is always at XLEN-1.
        div_lo  = w32_i ? (a_mag << WSH) : a_mag;
        nlast_i = w32_i ? CNT_W'(32 / UNROLL - 1) : CNT_W'(XLEN / UNROLL - 1);
`ifdef MDU_EARLY_OUT_EN
        a_zero  = (a_ext == {XLEN{1'b0}});
        min_w   = w32_i ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        min_mag = w32_i ? ext32(32'h8000_0000, 1'b0) : {1'b1, {(XLEN-1){1'b0}}};
        ones_w  = w32_i ? ext32(32'hFFFF_FFFF, 1'b0) : {XLEN{1'b1}};
        dz      = bus.funct3[2] && b_zero;
        ovf     = bus.funct3[2] && !bus.funct3[0] && (a_ext == min_w) && (b_ext == {XLEN{1'b1}});
        mz      = !bus.funct3[2] && (a_zero || b_zero);
`endif
    end

    // One CALC edge worth of work: UNROLL shift-add or restoring-divide steps
    logic [X2-1:0]   acc_s, mc_s;
    logic [XLEN-1:0] mp_s;
    logic [XLEN:0]   trial;

    always_comb begin
        acc_s = acc_q;
        mc_s  = mc_q;
        mp_s  = mp_q;
        trial = '0;
        for (int unsigned k = 0; k < UNROLL; k++) begin
            if (op_q[2]) begin
                trial = {acc_s[X2-1:XLEN], acc_s[XLEN-1]};
                if (trial >= {1'b0, mc_s[XLEN-1:0]}) begin
                    trial = trial - {1'b0, mc_s[XLEN-1:0]};
                    acc_s = {trial[XLEN-1:0], acc_s[XLEN-2:0], 1'b1};
                end else begin
                    acc_s = {trial[XLEN-1:0], acc_s[XLEN-2:0], 1'b0};
                end
            end else begin
                if (mp_s[0]) begin
                    acc_s = acc_s + mc_s;
                end
                mc_s = mc_s << 1;
                mp_s = mp_s >> 1;
            end
        end
    end

    // Sign fix-up and result selection
    logic [X2-1:0]   prod;
    logic [XLEN-1:0] q_abs, r_abs, fin_v;

    always_comb begin
        q_abs = acc_q[XLEN-1:0];
        r_abs = acc_q[X2-1:XLEN];
        prod  = neg_q ? -acc_q : acc_q;
        if (op_q[2]) begin
            fin_v = op_q[1] ? (negr_q ? -r_abs : r_abs) : (neg_q ? -q_abs : q_abs);
        end else begin
            fin_v = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[X2-1:XLEN];
        end
        if (w32_q) begin
            fin_v = ext32(fin_v[31:0], 1'b1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w32_d    = w32_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        cnt_d    = cnt_q;
        nlast_d  = nlast_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.funct3;
                    w32_d   = w32_i;
                    neg_d   = q_neg_i;
                    negr_d  = a_neg;
                    cnt_d   = '0;
                    nlast_d = nlast_i;
                    state_d = CALC;
                    if (bus.funct3[2]) begin
                        acc_d = {{XLEN{1'b0}}, div_lo};
                        mc_d  = X2'(b_mag);
                        mp_d  = '0;
                    end else begin
                        acc_d = '0;
                        mc_d  = X2'(a_mag);
                        mp_d  = b_mag;
                    end
`ifdef MDU_EARLY_OUT_EN
                    // Preload exactly what CALC would have left behind.
                    if (dz) begin
                        acc_d   = {a_mag, ones_w};
                        state_d = FIN;
                    end else if (ovf) begin
                        acc_d   = {{XLEN{1'b0}}, min_mag};
                        state_d = FIN;
                    end else if (mz) begin
                        acc_d   = '0;
                        state_d = FIN;
                    end
`endif
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_s;
                    mc_d  = mc_s;
                    mp_d  = mp_s;
                    if (cnt_q == nlast_q) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    result_d = fin_v;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            w32_q    <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            cnt_q    <= '0;
            nlast_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w32_q    <= w32_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            cnt_q    <= cnt_d;
            nlast_q  <= nlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter at XLEN=32/UNROLL=1 and XLEN=64/UNROLL=4.
// Stimulus pushes {expected result, expected done cycle}; a monitor pops on every done.
module tb_mdu_iter;
    logic    clock = 1'b0;
    logic    reset = 1'b1;
    longint  cyc   = 0;
    int      n_cmp  = 0;
    int      n_fail = 0;
    logic [31:0] last32 = '0;

    typedef struct {
        logic [63:0] res;
        longint      cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    mdu_iter_if #(.XLEN(32)) m32 ();
    mdu_iter_if #(.XLEN(64)) m64 ();

    mdu_iter #(.XLEN(32), .UNROLL(1)) u_dut32 (.clock(clock), .reset(reset), .bus(m32));
    mdu_iter #(.XLEN(64), .UNROLL(4)) u_dut64 (.clock(clock), .reset(reset), .bus(m64));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic longint lat_of(longint full, bit eo);
`ifdef MDU_EARLY_OUT_EN
        return eo ? 1 : full;
`else
        return eo ? full : full;
`endif
    endfunction

    // Pulse start for one edge, then scramble the inputs to prove they were latched.
    task automatic drive32(input logic [2:0] f3, input logic s32, input logic [31:0] a, input logic [31:0] b);
        m32.funct3 = f3; m32.s_32 = s32; m32.rs1 = a; m32.rs2 = b; m32.start = 1'b1;
        @(posedge clock);
        #1;
        m32.start = 1'b0; m32.funct3 = 3'b000; m32.rs1 = 32'hDEAD_BEEF; m32.rs2 = 32'h1234_5678;
    endtask

    task automatic drive64(input logic [2:0] f3, input logic s32, input logic [63:0] a, input logic [63:0] b);
        m64.funct3 = f3; m64.s_32 = s32; m64.rs1 = a; m64.rs2 = b; m64.start = 1'b1;
        @(posedge clock);
        #1;
        m64.start = 1'b0; m64.funct3 = 3'b011; m64.rs1 = 64'hDEAD_BEEF_CAFE_F00D; m64.rs2 = 64'h5;
    endtask

    task automatic issue32(input logic [2:0] f3, input logic s32, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input bit eo);
        exp_t e;
        e.res = 64'(res);
        e.cyc = cyc + 1 + lat_of(33, eo);
        q32.push_back(e);
        last32 = res;
        drive32(f3, s32, a, b);
    endtask

    task automatic issue64(input logic [2:0] f3, input logic s32, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res, input longint lat, input bit eo);
        exp_t e;
        e.res = res;
        e.cyc = cyc + 1 + lat_of(lat, eo);
        q64.push_back(e);
        drive64(f3, s32, a, b);
    endtask

    // Wait (bounded) until every expected completion has been seen; ends on a negedge.
    task automatic drain();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clock);
            if (q32.size() == 0 && q64.size() == 0) break;
        end
        if (i == 300) begin
            check("drain_timeout", 64'(q32.size() + q64.size()), 64'd0);
            q32.delete();
            q64.delete();
        end
    endtask

    task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit eo);
        issue32(f3, 1'b0, a, b, res, eo);
        drain();
    endtask

    task automatic run64(input logic [2:0] f3, input logic s32, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input longint lat, input bit eo);
        issue64(f3, s32, a, b, res, lat, eo);
        drain();
    endtask

    initial begin
        m32.start = 1'b0; m32.flush = 1'b0; m32.funct3 = '0; m32.s_32 = 1'b0; m32.rs1 = '0; m32.rs2 = '0;
        m64.start = 1'b0; m64.flush = 1'b0; m64.funct3 = '0; m64.s_32 = 1'b0; m64.rs1 = '0; m64.rs2 = '0;

        // Scoreboard monitor: every done pops one expectation
        fork
            forever begin
                exp_t e;
                @(negedge clock);
                if (!reset && m32.done) begin
                    if (q32.size() == 0) check("done32_unexpected", 64'(m32.done), 64'd0);
                    else begin
                        e = q32.pop_front();
                        check("result32", 64'(m32.result), e.res);
                        check("latency32", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (!reset && m64.done) begin
                    if (q64.size() == 0) check("done64_unexpected", 64'(m64.done), 64'd0);
                    else begin
                        e = q64.pop_front();
                        check("result64", m64.result, e.res);
                        check("latency64", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy32", 64'(m32.busy), 64'd0);
        check("rst_done32", 64'(m32.done), 64'd0);
        check("rst_result32", 64'(m32.result), 64'd0);
        check("rst_busy64", 64'(m64.busy), 64'd0);
        check("rst_result64", m64.result, 64'd0);

        // XLEN=32 directed vectors
        run32(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);   // MULH
        run32(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);   // MUL
        run32(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);   // DIV -7/2
        run32(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);   // REM -7%2
        run32(3'b101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);   // DIVU /0
        run32(3'b111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b1);   // REMU /0
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);   // DIV overflow
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);   // REM overflow
        run32(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);   // MULHSU -1*2
        run32(3'b000, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b1);   // MUL by zero
        issue32(3'b100, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);  // s_32 ignored
        drain();

        // Back-to-back: second start in the done cycle of the first
        issue32(3'b000, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0);
        begin
            int i;
            for (i = 0; i < 60; i++) begin
                @(negedge clock);
                if (m32.done) break;
            end
            check("b2b_first_done", 64'(m32.done), 64'd1);
        end
        issue32(3'b011, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        drain();

        // start while busy is ignored
        issue32(3'b101, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (10) @(negedge clock);
        m32.funct3 = 3'b000; m32.rs1 = 32'd2; m32.rs2 = 32'd2; m32.start = 1'b1;
        @(negedge clock);
        m32.start = 1'b0;
        drain();

        // flush 5 edges after start: busy drops, no done, result held
        drive32(3'b100, 1'b0, 32'd1000, 32'd10);
        repeat (4) @(posedge clock);
        #1;
        check("flush_busy_before", 64'(m32.busy), 64'd1);
        m32.flush = 1'b1;
        @(posedge clock);
        #1;
        m32.flush = 1'b0;
        check("flush_busy_after", 64'(m32.busy), 64'd0);
        check("flush_done", 64'(m32.done), 64'd0);
        check("flush_result_held", 64'(m32.result), 64'(last32));
        repeat (40) @(negedge clock);
        check("flush_result_later", 64'(m32.result), 64'(last32));

        // flush and start together in IDLE: start ignored
        m32.funct3 = 3'b000; m32.rs1 = 32'd9; m32.rs2 = 32'd9; m32.start = 1'b1; m32.flush = 1'b1;
        @(posedge clock);
        #1;
        m32.start = 1'b0; m32.flush = 1'b0;
        check("flush_start_busy", 64'(m32.busy), 64'd0);

        // asynchronous reset mid-CALC
        @(negedge clock);
        drive32(3'b100, 1'b0, 32'd1000, 32'd10);
        repeat (5) @(negedge clock);
        check("pre_reset_busy", 64'(m32.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(m32.busy), 64'd0);
        check("async_rst_done", 64'(m32.done), 64'd0);
        check("async_rst_result", 64'(m32.result), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("post_rst_result", 64'(m32.result), 64'd0);
        run32(3'b100, 32'd64, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);          // DIV 64/-3

        // XLEN=64, UNROLL=4 directed vectors
        run64(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 9, 1'b1);
        run64(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 9, 1'b0);
        run64(3'b111, 1'b1, 64'hFFFF_FFFF_0000_0011, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0002, 9, 1'b0);
        run64(3'b000, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0000_0000_0003, 64'h0000_0003_0000_0003, 17, 1'b0);
        run64(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 17, 1'b0);
        run64(3'b000, 1'b1, 64'hAAAA_AAAA_7FFF_FFFF, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 9, 1'b0);
        run64(3'b010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0);
        run64(3'b101, 1'b1, 64'h0000_0000_0000_0007, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 9, 1'b1);
        run64(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0);
        run64(3'b101, 1'b0, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b1);

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined RV32/RV64 core. It is the parametrised successor to the combinational `mul`/`div` path in EX. It executes all RV M-extension operations, including RV64 W forms, over multiple cycles with a start/done handshake. The hazard unit holds the pipeline on `busy`, and EX captures `result` on `done`. Width and bits-per-cycle are parameters, so throughput trades against area.

## Interface
- `XLEN`, 32: datapath width; 32 or 64.
- `UNROLL`, 1: quotient/multiplier bits retired per cycle; 1, 2, 4 or 8 (must divide 32).

Ports:
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request; sampled only in IDLE.
- `funct3` in 3: M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `s_32` in 1: W-form (operate on low 32 bits, sign-extend result). Ignored when XLEN=32 and for funct3 001–011.
- `rs1` in XLEN: dividend / multiplicand.
- `rs2` in XLEN: divisor / multiplier.
- `flush` in 1: abort the current operation (squashed EX instruction).
- `busy` out 1: operation in progress; pipeline must stall.
- `done` out 1: one-cycle pulse; `result` is valid.
- `result` out XLEN: registered result; held until the next completion.

## Operation
- States: IDLE, CALC, FIN.
- Operand width W = 32 if (`s_32` && XLEN=64 && funct3 ∉ {001,010,011}), else XLEN.
- Iteration count N = W/UNROLL.
- IDLE:
  - On `start`, latch `funct3`, `s_32` and operand magnitudes (absolute value for signed operands), plus the result-sign flags.
  - Clear the iteration counter; go to CALC.
- CALC:
  - Multiply: shift-add, UNROLL multiplier bits per edge into a 2W-bit accumulator.
  - Divide: restoring division, UNROLL quotient bits per edge.
  - After N edges, go to FIN.
- FIN:
  - Apply sign correction and select the output half or quotient/remainder.
  - Sign-extend bit 31 for W forms.
  - Write `result`, pulse `done`, return to IDLE.
- Result selection:
  - MUL: low W bits.
  - MULH/MULHSU/MULHU: high XLEN bits of the signed×signed, signed×unsigned or unsigned×unsigned product.
- Divide by zero: quotient = all ones (W bits, then extended); remainder = dividend.
- Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
  - Both special-case results fall out of the magnitude-plus-sign-fix datapath without special handling.
- `flush` in CALC or FIN:
  - Next edge goes to IDLE; no `done`.
  - `result` unchanged.
- `flush` and `start` in the same cycle: flush wins; start is ignored.
- `start` while `busy`: ignored; inputs need not be held after the sampling edge.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0. Asserting reset mid-operation aborts it with no `done`.

## Timing
- Edge E0 samples `start`; `busy`=1 after E0.
- Edges E1..EN iterate; EN+1 is FIN.
- After EN+1: `done`=1 for exactly one cycle, `busy`=0, `result` valid.
- Latency from E0 to `done` visible = N+1 edges.
  - XLEN=32, UNROLL=1: 33 edges.
  - XLEN=64 W-form, UNROLL=4: 9 edges.
- Back-to-back is allowed: `start` sampled on the edge that ends the `done` cycle begins the next op (zero idle cycles).
- `busy` is low in IDLE, including the `done` cycle.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed overflow (detected at E0) bypass CALC and go straight to FIN.
  - `done` follows after edge E1 (latency 1).
  - Multiply by zero also takes the bypass.
- Undefined: every operation takes the full N+1 edges. Results are bit-identical either way.

## Test plan
- XLEN=32, UNROLL=1: MULH rs1=0x80000000, rs2=0x80000000 → `done` after 33 edges, result=0x40000000; MUL of the same → 0x00000000.
- XLEN=32: DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU rs1=7, rs2=0 → 0xFFFFFFFF; REMU → 7.
- XLEN=64, UNROLL=4, `s_32`=1: DIV rs1=0x80000000, rs2=0xFFFFFFFFFFFFFFFF → result 0xFFFFFFFF80000000, latency 9 edges (1 with `MDU_EARLY_OUT_EN`).
- Back-to-back: second `start` (MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE) in the `done` cycle of the first → second `done` exactly N+1 edges later, first result seen for one cycle.
- Abort: `flush` 5 edges after `start` → `busy` low next edge, no `done`, `result` retains its previous value; repeat with reset asserted asynchronously mid-CALC → all outputs 0 immediately.
- `start` pulsed while `busy` with different operands → ignored; original result returned on time.
